serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_fa_cell.sv | 15 +
 rtl/serial_adder.sv | 107 ++++++++++
 tb/tb_serial_adder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit full-adder cell used by the serial adder datapath (purely combinational).
module serial_fa_cell
  import serial_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one result bit per clock, LSB first, through a single full-adder cell.
// Optional signed-overflow output ovf when SERIAL_ADDER_OVF_EN is defined.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             fa_s, fa_co;
  logic             last_bit, accept;

  assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));
  // start is only honoured outside SHIFT, so a request while busy is dropped
  assign accept   = start && (state_reg != SHIFT);

  serial_fa_cell u_fa (
    .a  (a_reg[0]),
    .b  (b_reg[0]),
    .ci (carry_reg),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == SHIFT);
    done = (state_reg == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= b;
      carry_reg <= cin;
      cnt_reg   <= '0;
    end else if (state_reg == SHIFT) begin
      sum_reg   <= {fa_s, sum_reg[WIDTH-1:1]};
      a_reg     <= a_reg >> 1;
      b_reg     <= b_reg >> 1;
      carry_reg <= fa_co;
      cnt_reg   <= cnt_reg + CNT_W'(1);
    end
  end

  assign sum  = sum_reg;
  assign cout = carry_reg;

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_reg;

  // On the MSB step carry_reg is the carry into the MSB and fa_co the carry out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if ((state_reg == SHIFT) && last_bit) begin
      ovf_reg <= carry_reg ^ fa_co;
    end
  end

  assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed scenarios, random operands, WIDTH=4 sweep.
`timescale 1ns/1ps
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, cin;
  logic [7:0] a, b;
  logic       busy, done, cout;
  logic [7:0] sum;
  logic       start4, cin4;
  logic [3:0] a4, b4;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf, ovf4;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf4)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer addition and the two's-complement overflow rule
  function automatic logic [8:0] ref_sum(input logic [7:0] av, input logic [7:0] bv, input logic ci);
    return 9'(av) + 9'(bv) + 9'(ci);
  endfunction

  function automatic logic ref_ovf(input logic [7:0] av, input logic [7:0] bv, input logic ci);
    int sa, sb, s;
    sa = $signed(av);
    sb = $signed(bv);
    s  = sa + sb + int'(ci);
    return (s > 127) || (s < -128);
  endfunction

  task automatic launch(input logic [7:0] av, input logic [7:0] bv, input logic ci);
    @(negedge clk);
    a = av; b = bv; cin = ci; start = 1'b1;
    @(posedge clk); #1;
  endtask

  // Called just after the accepting edge; glitch = SHIFT cycle index (0-based) to pulse a stray start
  task automatic wait_done(input string tag, input logic [7:0] av, input logic [7:0] bv,
                           input logic ci, input int glitch, input logic hold);
    int n;
    logic [8:0] r;
    n = 0;
    r = ref_sum(av, bv, ci);
    check({tag, " busy"}, 64'(busy), 64'(1));
    while (!done && n < 20) begin
      @(negedge clk);
      start = hold;
      if (n == glitch) begin
        start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(8));
    check({tag, " sum"}, 64'(sum), 64'(r[7:0]));
    check({tag, " cout"}, 64'(cout), 64'(r[8]));
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, " ovf"}, 64'(ovf), 64'(ref_ovf(av, bv, ci)));
`endif
    $display("txn %s: %02h + %02h + %0d -> cout=%0d sum=%02h (latency %0d)", tag, av, bv, ci, cout, sum, n);
  endtask

  task automatic do_add(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input int glitch);
    launch(av, bv, ci);
    wait_done(tag, av, bv, ci, glitch, 1'b0);
    @(posedge clk); #1;
    check({tag, " done pulse"}, 64'(done), 64'(0));
    check({tag, " idle busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    logic [4:0] r4;
    int         n;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset sum", 64'(sum), 64'(0));
    check("reset cout", 64'(cout), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    do_add("zero", 8'h00, 8'h00, 1'b0, -1);
    do_add("ff_plus_1", 8'hFF, 8'h01, 1'b0, -1);
    do_add("7f_plus_1", 8'h7F, 8'h01, 1'b0, -1);
    do_add("a5_5a_c1", 8'hA5, 8'h5A, 1'b1, -1);
    do_add("ignored_start", 8'hA5, 8'h5A, 1'b1, 2);

    // Back-to-back: start held through done, next operation starts with no idle cycle
    launch(8'h03, 8'h04, 1'b0);
    wait_done("b2b_first", 8'h03, 8'h04, 1'b0, -1, 1'b1);
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    check("b2b no idle", 64'(busy), 64'(1));
    wait_done("b2b_second", 8'h10, 8'h20, 1'b0, -1, 1'b0);
    @(posedge clk); #1;
    check("b2b done pulse", 64'(done), 64'(0));

    // Asynchronous reset in the middle of SHIFT
    launch(8'hFF, 8'hFF, 1'b0);
    @(negedge clk); start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst busy", 64'(busy), 64'(0));
    check("midrst done", 64'(done), 64'(0));
    check("midrst sum", 64'(sum), 64'(0));
    check("midrst cout", 64'(cout), 64'(0));
`ifdef SERIAL_ADDER_OVF_EN
    check("midrst ovf", 64'(ovf), 64'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    do_add("after_rst", 8'h01, 8'h01, 1'b0, -1);

    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      do_add($sformatf("rand%0d", i), ra, rb, rc, ((i % 5) == 0) ? int'($urandom_range(0, 6)) : -1);
    end

    // Exhaustive WIDTH=4 sweep on the second instance
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          @(negedge clk);
          a4 = 4'(ai); b4 = 4'(bi); cin4 = 1'(ci); start4 = 1'b1;
          @(negedge clk);
          start4 = 1'b0;
          n = 0;
          while (!done4 && n < 12) begin
            @(posedge clk); #1;
            n++;
          end
          r4 = 5'(ai) + 5'(bi) + 5'(ci);
          check($sformatf("sweep %0d+%0d+%0d", ai, bi, ci), 64'({cout4, sum4}), 64'(r4));
`ifdef SERIAL_ADDER_OVF_EN
          check($sformatf("sweep ovf %0d+%0d+%0d", ai, bi, ci), 64'(ovf4),
                64'((a4[3] == b4[3]) && (r4[3] != a4[3])));
`endif
          $display("txn sweep4: %0h + %0h + %0d -> %02h", ai, bi, ci, {cout4, sum4});
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
